// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit seven-segment driver.
// Latches a packed BCD word on iLOAD and scans the digits round-robin,
// one digit slot every SCAN_DIV clocks, with optional leading-zero blanking.
// Optional macro SEG7_HEX_EN: nibbles 10-15 decode to A,b,C,d,E,F instead of
// blank.
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    iCLK,
    input  logic                    iRST_N,
    input  logic                    iLOAD,
    input  logic [4*NUM_DIGITS-1:0] iDATA,
    input  logic                    iBLANK_LZ,
    output logic [6:0]              oSEG7,
    output logic [NUM_DIGITS-1:0]   oDIG,
    output logic                    oFRAME
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]    SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_ONE = NUM_DIGITS'(1);

    // Decode one nibble into segment levels {g,f,e,d,c,b,a}, board polarity.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] al;
        case (nib)
            4'd0:    al = 7'b1000000;
            4'd1:    al = 7'b1111001;
            4'd2:    al = 7'b0100100;
            4'd3:    al = 7'b0110000;
            4'd4:    al = 7'b0011001;
            4'd5:    al = 7'b0010010;
            4'd6:    al = 7'b0000010;
            4'd7:    al = 7'b1111000;
            4'd8:    al = 7'b0000000;
            4'd9:    al = 7'b0010000;
`ifdef SEG7_HEX_EN
            4'd10:   al = 7'b0001000;
            4'd11:   al = 7'b0000011;
            4'd12:   al = 7'b1000110;
            4'd13:   al = 7'b0100001;
            4'd14:   al = 7'b0000110;
            4'd15:   al = 7'b0001110;
`endif
            default: al = 7'h7F;
        endcase
        return (SEG_ACTIVE_LOW != 0) ? al : ~al;
    endfunction

    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;
    logic                    frame_q, frame_d;

    logic                    tick;
    logic [3:0]              nib      [NUM_DIGITS];
    logic [NUM_DIGITS:1]     zero_from;
    logic [NUM_DIGITS-1:0]   blank_vec;

    assign tick = (presc_q == PRESC_MAX);

    // zero_from[k] is set when every nibble from k up to the top is zero;
    // digit 0 is never blanked so a zero value still shows a single "0".
    assign zero_from[NUM_DIGITS] = 1'b1;
    assign blank_vec[0]          = 1'b0;
    assign nib[0]                = shadow_q[3:0];
    generate
        for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
            assign nib[gi]       = shadow_q[4*gi +: 4];
            assign zero_from[gi] = (nib[gi] == 4'd0) && zero_from[gi+1];
            assign blank_vec[gi] = iBLANK_LZ && zero_from[gi];
        end
    endgenerate

    // Next-state: prescaler, shadow capture and per-tick digit/segment update.
    // The tick decodes shadow_q, so a load on the same edge shows next slot.
    always_comb begin
        presc_d  = tick ? '0 : presc_q + 1'b1;
        shadow_d = iLOAD ? iDATA : shadow_q;
        idx_d    = idx_q;
        dig_d    = dig_q;
        seg_d    = seg_q;
        frame_d  = 1'b0;
        if (tick) begin
            idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
            dig_d   = ~(DIG_ONE << idx_d);
            seg_d   = blank_vec[idx_d] ? SEG_OFF : decode(nib[idx_d]);
            frame_d = (idx_d == '0);
        end
    end

    // State register; index resets to the last digit so the first tick lands on digit 0.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            shadow_q <= '0;
            presc_q  <= '0;
            idx_q    <= IDX_MAX;
            dig_q    <= '1;
            seg_q    <= SEG_OFF;
            frame_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            dig_q    <= dig_d;
            seg_q    <= seg_d;
            frame_q  <= frame_d;
        end
    end

    assign oSEG7  = seg_q;
    assign oDIG   = dig_q;
    assign oFRAME = frame_q;

endmodule
